// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush/freeze sequencing, operand forwarding selects and memory-wait timeout for the 5-stage core
module pipe_hazard_ctrl #(
  parameter int REG_W   = 4,
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] src1,
  input  logic [REG_W-1:0] src2,
  input  logic             two_src,
  input  logic             id_valid,
  input  logic [REG_W-1:0] exe_dst,
  input  logic             exe_wb_en,
  input  logic             exe_mem_read,
  input  logic [REG_W-1:0] mem_dst,
  input  logic             mem_wb_en,
  input  logic [REG_W-1:0] wb_dst,
  input  logic             wb_wb_en,
  input  logic             fwd_en,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             freeze_front,
  output logic             bubble_id_exe,
  output logic             flush_if_id,
  output logic             freeze_all,
  output logic [1:0]       sel_src1,
  output logic [1:0]       sel_src2,
  output logic             mem_error,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);
  localparam int WW = $clog2(TIMEOUT + 1);
  typedef enum logic {RUN, MEM_WAIT} state_t;
  state_t           state_q;
  logic [WW-1:0]    wait_q;
  logic             mem_error_q;
  logic [CNT_W-1:0] stall_q, flush_q;
  logic             m_exe, m_mem, hazard, timeout;

  // MEM result beats WB value when both stages write the same register
  function automatic logic [1:0] fwd_sel(input logic [REG_W-1:0] idx);
    return (mem_wb_en && idx == mem_dst) ? 2'd1 : (wb_wb_en && idx == wb_dst) ? 2'd2 : 2'd0;
  endfunction

  // Control outputs act in the same cycle: freeze_all masks branch flush, which masks the hazard stall
  always_comb begin
    m_exe         = src1 == exe_dst || (two_src && src2 == exe_dst);
    m_mem         = src1 == mem_dst || (two_src && src2 == mem_dst);
    hazard        = id_valid && ((exe_wb_en && m_exe && (!fwd_en || exe_mem_read)) || (!fwd_en && mem_wb_en && m_mem));
    timeout       = state_q == MEM_WAIT && !mem_ready && wait_q == WW'(TIMEOUT);
    freeze_all    = !rst && (state_q == RUN ? mem_req && !mem_ready : !mem_ready && !timeout);
    flush_if_id   = !rst && !freeze_all && branch_taken;
    bubble_id_exe = !rst && !freeze_all && (branch_taken || hazard);
    freeze_front  = !rst && !freeze_all && !branch_taken && hazard;
    sel_src1      = (rst || !fwd_en) ? 2'd0 : fwd_sel(src1);
    sel_src2      = (rst || !fwd_en) ? 2'd0 : fwd_sel(src2);
  end

  // Memory-wait FSM with timeout, sticky error and saturating performance counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      wait_q      <= '0;
      mem_error_q <= 1'b0;
      stall_q     <= '0;
      flush_q     <= '0;
    end else begin
      if (state_q == RUN) begin
        if (mem_req && !mem_ready) begin
          state_q <= MEM_WAIT;
          wait_q  <= WW'(1);
        end
      end else if (mem_ready || timeout) begin
        state_q <= RUN;
        wait_q  <= '0;
      end else wait_q <= wait_q + 1'b1;
      if (timeout) mem_error_q <= 1'b1;
      if ((freeze_all || freeze_front) && !(&stall_q)) stall_q <= stall_q + 1'b1;
      if (flush_if_id && !(&flush_q)) flush_q <= flush_q + 1'b1;
    end
  end

  assign mem_error    = mem_error_q;
  assign stall_cycles = stall_q;
  assign flush_count  = flush_q;
endmodule
